// File: rtl/ps2_host_ctrl.sv
`timescale 1ns/1ps
// ps2_host_ctrl: PS/2 host-to-device command controller.
// Sends a one- or two-byte command with the host request-to-send sequence
// on the open-drain clock/data pads, then collects the 0xFA/0xFE reply from
// the external receiver. Optional resend support is built in when the macro
// PS2_CTRL_RETRY_EN is defined; without it any 0xFE or missing ack aborts.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_user,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_NOACK   = 2'd1;
  localparam logic [1:0] ERR_RESEND  = 2'd2;
  localparam logic [1:0] ERR_UNEXP   = 2'd3;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  if (INHIBIT_CYC < 32'sd1 || TIMEOUT_CYC < 32'sd1 || MAX_RETRY < 32'sd0) begin : g_bad_cfg
    $error("ps2_host_ctrl: INHIBIT_CYC/TIMEOUT_CYC must be >= 1 and MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_ACKBIT    = 3'd4,
    S_WAIT_RESP = 3'd5
  } state_e;

  // Odd parity bit for a frame: set when the data byte has an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       cur_q, cur_d;
  logic [7:0]       arg_q, arg_d;
  logic             has_arg_q, has_arg_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             idle_q, idle_d;
  logic             done_q, done_d;
  logic             err_q;
  logic [1:0]       err_code_q, err_code_d;
  logic             abort_s;
  logic [1:0]       abort_code_s;
`ifdef PS2_CTRL_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0] RTY_ONE     = RTY_W'(1);
  logic [RTY_W-1:0] retry_q, retry_d;
`endif

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic clk_fall_s;

  // Two-flop synchronizers for both pads plus the previous-clock register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign clk_fall_s = clk_prev_q & ~clk_s2_q;

  // Next-state, counters and registered pad/status values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    cur_d        = cur_q;
    arg_d        = arg_q;
    has_arg_d    = has_arg_q;
    data_oe_d    = data_oe_q;
    clk_oe_d     = 1'b0;
    done_d       = 1'b0;
    err_code_d   = err_code_q;
    abort_s      = 1'b0;
    abort_code_s = ERR_TIMEOUT;
`ifdef PS2_CTRL_RETRY_EN
    retry_d      = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = 4'd0;
        if (cmd_valid) begin
          cur_d     = cmd_byte;
          arg_d     = cmd_arg;
          has_arg_d = cmd_has_arg;
          state_d   = S_INHIBIT;
`ifdef PS2_CTRL_RETRY_EN
          retry_d   = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = S_RTS;
          cnt_d   = '0;
          bit_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RTS: begin
        if (cnt_q == TO_LAST) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (clk_fall_s) begin
            state_d   = S_SEND;
            bit_d     = 4'd1;
            data_oe_d = ~cur_q[0];
          end else begin
            state_d = S_RTS;
          end
        end
      end

      // bit_q holds the number of falling edges already served in this frame.
      S_SEND: begin
        if (cnt_q == TO_LAST) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (clk_fall_s) begin
            bit_d = bit_q + 4'd1;
            if (bit_q < 4'd8) begin
              data_oe_d = ~cur_q[bit_q[2:0]];
            end else if (bit_q == 4'd8) begin
              data_oe_d = ~odd_parity(cur_q);
            end else begin
              data_oe_d = 1'b0;
              state_d   = S_ACKBIT;
            end
          end else begin
            state_d = S_SEND;
          end
        end
      end

      S_ACKBIT: begin
        if (cnt_q == TO_LAST) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (clk_fall_s) begin
            if (!data_s2_q) begin
              state_d = S_WAIT_RESP;
              cnt_d   = '0;
            end else begin
`ifdef PS2_CTRL_RETRY_EN
              if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + RTY_ONE;
                state_d = S_INHIBIT;
                cnt_d   = '0;
              end else begin
                abort_s      = 1'b1;
                abort_code_s = ERR_NOACK;
              end
`else
              abort_s      = 1'b1;
              abort_code_s = ERR_NOACK;
`endif
            end
          end else begin
            state_d = S_ACKBIT;
          end
        end
      end

      // A reply strobe takes priority over a timeout expiring in the same cycle.
      S_WAIT_RESP: begin
        if (rx_valid) begin
          case (rx_byte)
            RSP_ACK: begin
`ifdef PS2_CTRL_RETRY_EN
              retry_d = '0;
`endif
              if (has_arg_q) begin
                cur_d     = arg_q;
                has_arg_d = 1'b0;
                state_d   = S_INHIBIT;
                cnt_d     = '0;
              end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
            RSP_RESEND: begin
`ifdef PS2_CTRL_RETRY_EN
              if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + RTY_ONE;
                state_d = S_INHIBIT;
                cnt_d   = '0;
              end else begin
                abort_s      = 1'b1;
                abort_code_s = ERR_RESEND;
              end
`else
              abort_s      = 1'b1;
              abort_code_s = ERR_RESEND;
`endif
            end
            default: begin
              abort_s      = 1'b1;
              abort_code_s = ERR_UNEXP;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_s) begin
      state_d    = S_IDLE;
      err_code_d = abort_code_s;
    end else begin
      err_code_d = err_code_d;
    end

    // Pad drive follows the state being entered so the outputs can be registered.
    case (state_d)
      S_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = (cnt_d == INH_LAST);
      end
      S_RTS:   data_oe_d = 1'b1;
      S_SEND:  data_oe_d = data_oe_d;
      default: data_oe_d = 1'b0;
    endcase

    idle_d = (state_d == S_IDLE);
  end

  // State, datapath and registered outputs; reset releases both pads at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      cur_q      <= 8'd0;
      arg_q      <= 8'd0;
      has_arg_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
`ifdef PS2_CTRL_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      cur_q      <= cur_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      idle_q     <= idle_d;
      done_q     <= done_d;
      err_q      <= abort_s;
      err_code_q <= err_code_d;
`ifdef PS2_CTRL_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign cmd_ready  = idle_q;
  assign rx_user    = idle_q;
  assign busy       = ~idle_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for ps2_host_ctrl: a device model clocks frames out of the
// host, decodes them against expected bytes, and replies through rx_valid.
module tb_ps2_host_ctrl;

  localparam int INH  = 20;
  localparam int TO   = 1500;
  localparam int MR   = 3;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_has_arg;
  logic [7:0] cmd_byte, cmd_arg;
  logic       ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;
  logic       rx_valid, rx_user, busy, done, err;
  logic [7:0] rx_byte;
  logic [1:0] err_code;
  logic       dev_clk_rel, dev_data_rel;

  assign ps2clk_in  = dev_clk_rel & ~ps2clk_oe;
  assign ps2data_in = dev_data_rel & ~ps2data_oe;

  always #5 clk = ~clk;

  ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_user(rx_user),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  int cmp_cnt = 0;
  int mis_cnt = 0;
  logic [8:0] exp_frame_q[$];   // {parity, byte}
  logic [2:0] exp_end_q[$];     // {err, code}; done is 3'b000

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every done/err pulse consumes one expected outcome.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && (done || err)) begin
      check_eq("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (exp_end_q.size() == 0) begin
        check_eq("unexpected_end", exp_end_q.size(), 32'd1);
      end else begin
        e = exp_end_q.pop_front();
        check_eq("end_result", {29'd0, err, (err ? err_code : 2'b00)}, {29'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic dev_pulse(output logic smp);
    dev_clk_rel = 1'b0;
    repeat (HALF) @(negedge clk);
    smp = ps2data_in;
    dev_clk_rel = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic dev_wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * TO; i++) begin
      if (!ps2clk_oe && ps2data_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Clock one full host frame, acknowledge it, and compare against the scoreboard.
  task automatic dev_frame();
    bit ok;
    logic [9:0] bits;
    logic s;
    logic [8:0] e;
    dev_wait_rts(ok);
    check_eq("rts_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      repeat (2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        dev_pulse(s);
        bits[k] = s;
      end
      dev_data_rel = 1'b0;
      repeat (2) @(negedge clk);
      dev_pulse(s);
      dev_data_rel = 1'b1;
      if (exp_frame_q.size() == 0) begin
        check_eq("unexpected_frame", exp_frame_q.size(), 32'd1);
      end else begin
        e = exp_frame_q.pop_front();
        check_eq("frame_byte", {24'd0, bits[7:0]}, {24'd0, e[7:0]});
        check_eq("frame_parity", {31'd0, bits[8]}, {31'd0, e[8]});
        check_eq("frame_stop", {31'd0, bits[9]}, 32'd1);
      end
    end
  endtask

  task automatic dev_reply(input logic [7:0] b);
    repeat (4) @(negedge clk);
    check_eq("rx_user_wait", {31'd0, rx_user}, 32'd0);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Issue a command and check the inhibit window; returns in the first RTS cycle.
  task automatic issue(input logic [7:0] c, input logic ha, input logic [7:0] a, input bit noise);
    int hi;
    int both;
    hi = 0;
    both = 0;
    check_eq("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);
    for (int i = 0; i < INH + 10; i++) begin
      if (!ps2clk_oe) break;
      hi++;
      if (ps2data_oe) both++;
      if (noise && hi == 5) begin
        rx_valid = 1'b1; rx_byte = 8'hFA;
        cmd_valid = 1'b1; cmd_byte = 8'h11; cmd_has_arg = 1'b1;
      end else begin
        rx_valid = 1'b0;
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    cmd_valid = 1'b0;
    check_eq("inhibit_len", hi, INH);
    check_eq("data_low_last_inhibit", both, 32'd1);
    check_eq("rts_data_low", {31'd0, ps2data_oe}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4 * TO; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
    check_eq("rx_user_idle", {31'd0, rx_user}, 32'd1);
  endtask

  initial begin
    int n;
    logic s;
    bit ok;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_has_arg = 1'b0; cmd_arg = 8'h00;
    rx_valid = 1'b0; rx_byte = 8'h00;
    dev_clk_rel = 1'b1; dev_data_rel = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {24'd0, ps2clk_oe, ps2data_oe, cmd_ready, busy, done, err, err_code},
             {24'd0, 8'b0010_0000});
    check_eq("rst_rx_user", {31'd0, rx_user}, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED + 0x02, both acknowledged.
    exp_frame_q.push_back({1'b1, 8'hED});
    exp_frame_q.push_back({1'b0, 8'h02});
    exp_end_q.push_back(3'b000);
    issue(8'hED, 1'b1, 8'h02, 1'b0);
    dev_frame();
    dev_reply(8'hFA);
    dev_frame();
    dev_reply(8'hFA);
    wait_idle("ed02_idle");

    // 0xFF with a silent device: timeout measured from RTS entry.
    exp_end_q.push_back(3'b100);
    issue(8'hFF, 1'b0, 8'h00, 1'b0);
    n = 0;
    for (int i = 1; i <= TO + 10; i++) begin
      @(negedge clk);
      n = i;
      if (err) break;
    end
    check_eq("timeout_latency", n, TO);
    check_eq("timeout_pads", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
    wait_idle("timeout_idle");

    // 0xF4 answered with resend requests.
`ifdef PS2_CTRL_RETRY_EN
    repeat (3) exp_frame_q.push_back({1'b0, 8'hF4});
    exp_end_q.push_back(3'b000);
    issue(8'hF4, 1'b0, 8'h00, 1'b0);
    dev_frame();
    dev_reply(8'hFE);
    dev_frame();
    dev_reply(8'hFE);
    dev_frame();
    dev_reply(8'hFA);
`else
    exp_frame_q.push_back({1'b0, 8'hF4});
    exp_end_q.push_back(3'b110);
    issue(8'hF4, 1'b0, 8'h00, 1'b0);
    dev_frame();
    dev_reply(8'hFE);
`endif
    wait_idle("resend_idle");

    // Unexpected reply 0xAA.
    exp_frame_q.push_back({1'b0, 8'hF4});
    exp_end_q.push_back(3'b111);
    issue(8'hF4, 1'b0, 8'h00, 1'b0);
    dev_frame();
    dev_reply(8'hAA);
    wait_idle("unexp_idle");

    // Asynchronous reset while data bit 4 (a zero of 0xED) is driven.
    issue(8'hED, 1'b0, 8'h00, 1'b0);
    dev_wait_rts(ok);
    check_eq("rst_test_rts", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) dev_pulse(s);
    dev_clk_rel = 1'b0;
    repeat (HALF) @(negedge clk);
    check_eq("bit4_driven", {30'd0, ps2clk_oe, ps2data_oe}, 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("async_release", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
    @(negedge clk);
    dev_clk_rel = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_state", {29'd0, cmd_ready, busy, rx_user}, 32'd5);

    // Stray reply and command during INHIBIT are ignored.
    exp_frame_q.push_back({1'b0, 8'hF4});
    exp_end_q.push_back(3'b000);
    issue(8'hF4, 1'b0, 8'h00, 1'b1);
    dev_frame();
    dev_reply(8'hFA);
    wait_idle("noise_idle");

    repeat (10) @(negedge clk);
    check_eq("frames_drained", exp_frame_q.size(), 32'd0);
    check_eq("ends_drained", exp_end_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
